mips32_fetch_unit: RTL

Instruction-fetch stage for the pipelined MIPS32 core. Sits directly upstream of decode. It issues word reads to instruction memory and buffers the returned words with their next-PC in a small prefetch queue. It hands them to decode over a valid/ready handshake, squashes on branch redirect and stops fetching once an HLT has been fetched.

---
 rtl/mips32_pkg.sv | 24 ++
 rtl/mips32_fetch_fifo.sv | 65 ++++++
 rtl/mips32_fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 core definitions: instruction width, opcode field and opcode encodings
// used by fetch and decode.
package mips32_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  typedef enum logic [5:0] {
    OPC_RTYPE = 6'h00,
    OPC_JAL   = 6'h03,
    OPC_ADDI  = 6'h08,
    OPC_ADDIU = 6'h09,
    OPC_SLTI  = 6'h0a,
    OPC_LW    = 6'h23,
    OPC_SW    = 6'h2b,
    OPC_HLT   = 6'h3f
  } opcode_e;

  function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
    return (instr[OPC_MSB:OPC_LSB] == OPC_HLT);
  endfunction

endpackage

// File: rtl/mips32_fetch_fifo.sv
// Prefetch queue between instruction memory and decode: DEPTH entries of {instr, npc},
// synchronous flush, occupancy count exposed for the fetch credit check.
module mips32_fetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 42
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // Qualify push/pop against occupancy; an empty queue never bypasses a push.
  always_comb begin
    push_ok_s = push && (count_r != CNT_W'(DEPTH));
    pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
  end

  // Storage, pointers and occupancy; flush drops every entry including the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/mips32_fetch_unit.sv
// Instruction-fetch stage: issues one-word reads, queues returned words with their
// next-PC for decode, squashes on redirect and stops fetching once HLT is seen.
module mips32_fetch_unit
  import mips32_pkg::*;
#(
  parameter int              ADDR_W   = 10,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_npc,
  output logic              halted
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = INSTR_W + ADDR_W;

  logic              run_r;
  logic              inflight_r;
  logic              tag_r;
  logic              epoch_r;
  logic              stop_r;
  logic              halted_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] req_npc_r;

  logic [CNT_W-1:0]  count_s;
  logic [ENT_W-1:0]  head_s;
  logic [CNT_W:0]    used_s;
  logic              redirect_s;
  logic              push_s;
  logic              hlt_push_s;
  logic              credit_s;
  logic              issue_s;
  logic              pop_s;
  logic              head_valid_s;

  // Issue, push and pop decisions. An HLT arriving this cycle already blocks the next
  // request so nothing past it is ever fetched; pops are not credited until next cycle.
  always_comb begin
    redirect_s   = redirect_valid && !halted_r;
    push_s       = inflight_r && (tag_r == epoch_r) && !redirect_s;
    hlt_push_s   = push_s && is_hlt(imem_rdata);
    used_s       = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r};
    credit_s     = (used_s < (CNT_W+1)'(DEPTH));
    issue_s      = run_r && !stop_r && !hlt_push_s && !halted_r && !redirect_s && credit_s;
    head_valid_s = (count_s != {CNT_W{1'b0}});
    pop_s        = head_valid_s && id_ready && !redirect_s;
  end

  // PC, credit, epoch, stop and halt state; redirect wins over issue and HLT detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r      <= 1'b0;
      inflight_r <= 1'b0;
      tag_r      <= 1'b0;
      epoch_r    <= 1'b0;
      stop_r     <= 1'b0;
      halted_r   <= 1'b0;
      pc_r       <= RESET_PC;
      req_npc_r  <= {ADDR_W{1'b0}};
    end else begin
      run_r      <= 1'b1;
      inflight_r <= issue_s;
      if (issue_s) begin
        pc_r      <= pc_r + ADDR_W'(1);
        req_npc_r <= pc_r + ADDR_W'(1);
        tag_r     <= epoch_r;
      end
      if (redirect_s) begin
        pc_r    <= redirect_pc;
        epoch_r <= ~epoch_r;
        stop_r  <= 1'b0;
      end else if (hlt_push_s) begin
        stop_r <= 1'b1;
      end
      if (pop_s && is_hlt(head_s[ENT_W-1 -: INSTR_W])) begin
        halted_r <= 1'b1;
      end
    end
  end

  mips32_fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_s),
    .push      (push_s),
    .push_data ({imem_rdata, req_npc_r}),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (count_s)
  );

  assign imem_en   = issue_s;
  assign imem_addr = pc_r;
  assign id_valid  = head_valid_s;
  assign id_instr  = head_s[ENT_W-1 -: INSTR_W];
  assign id_npc    = head_s[ADDR_W-1:0];
  assign halted    = halted_r;

endmodule
